ahb_lite_wait_mem: RTL and testbench

AHB-Lite slave memory model with a configurable word depth and a fixed number of data-phase wait states. It supports byte, halfword and word transfers with byte-lane writes, and pipelines address and data phases correctly, forwarding write data into a read that immediately follows. It can optionally emulate SDRAM refresh stalls. The block stands in for the SDRAM controller in system benches and early FPGA bring-up, so masters can be exercised against realistic back-pressure.

---
 rtl/ahb_lite_mem_pkg.sv | 14 +
 rtl/ahb_lite_wait_mem_if.sv | 16 +
 rtl/ahb_lite_mem_ram.sv | 23 ++
 rtl/ahb_lite_wait_mem.sv | 134 +++++++++++++
 tb/tb_ahb_lite_wait_mem.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/ahb_lite_mem_pkg.sv
// ahb_lite_mem_pkg: shared AHB-Lite encodings, FSM states and lane helpers for ahb_lite_wait_mem.
package ahb_lite_mem_pkg;
    typedef enum logic [1:0] {HT_IDLE = 2'b00, HT_BUSY = 2'b01, HT_NONSEQ = 2'b10, HT_SEQ = 2'b11} htrans_e;
    typedef enum logic [2:0] {HS_BYTE = 3'd0, HS_HALF = 3'd1, HS_WORD = 3'd2} hsize_e;
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ERR1, S_ERR2} state_e;

    function automatic logic [3:0] lane_mask(input logic [2:0] size, input logic [1:0] off);
        return size == HS_BYTE ? 4'b0001 << off : size == HS_HALF ? 4'b0011 << off : 4'b1111;
    endfunction

    function automatic logic [31:0] be_bits(input logic [3:0] be);
        return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    endfunction
endpackage

// File: rtl/ahb_lite_wait_mem_if.sv
// ahb_lite_wait_mem_if: AHB-Lite bus bundle between a master and the wait-state memory slave.
interface ahb_lite_wait_mem_if;
    logic [31:0] HADDR;
    logic [2:0]  HBURST;
    logic        HSEL;
    logic [2:0]  HSIZE;
    logic [1:0]  HTRANS;
    logic [31:0] HWDATA;
    logic        HWRITE;
    logic [31:0] HRDATA;
    logic        HREADY;
    logic        HRESP;

    modport master (output HADDR, HBURST, HSEL, HSIZE, HTRANS, HWDATA, HWRITE, input HRDATA, HREADY, HRESP);
    modport slave (input HADDR, HBURST, HSEL, HSIZE, HTRANS, HWDATA, HWRITE, output HRDATA, HREADY, HRESP);
endinterface

// File: rtl/ahb_lite_mem_ram.sv
// ahb_lite_mem_ram: 2**ADDR_WIDTH x 32 RAM, byte-enable synchronous write, synchronous read, no reset.
module ahb_lite_mem_ram #(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic [3:0]            be_i,
    input  logic [ADDR_WIDTH-1:0] waddr_i,
    input  logic [31:0]           wdata_i,
    input  logic                  re_i,
    input  logic [ADDR_WIDTH-1:0] raddr_i,
    output logic [31:0]           rdata_o
);
    logic [31:0] mem_q [2**ADDR_WIDTH];
    logic [31:0] rdata_q;

    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++)
            if (be_i[b]) mem_q[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
        if (re_i) rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;
endmodule

// File: rtl/ahb_lite_wait_mem.sv
// ahb_lite_wait_mem: AHB-Lite slave memory with fixed data-phase wait states and write-to-read forwarding.
// Define AHB_MEM_REFRESH_EN to add periodic SDRAM-style refresh stalls.
module ahb_lite_wait_mem
    import ahb_lite_mem_pkg::*;
#(
    parameter int ADDR_WIDTH     = 10,
    parameter int WAIT_STATES    = 1,
    parameter int REFRESH_PERIOD = 64,
    parameter int REFRESH_CYCLES = 4
) (
    input  logic                HCLK,
    input  logic                HRESET,
    ahb_lite_wait_mem_if.slave  bus
);
    typedef logic [ADDR_WIDTH-1:0] idx_t;

    state_e      state_q;
    logic [4:0]  cnt_q;
    logic        hready_q, hresp_q;
    logic        wr_pend_q;
    idx_t        wr_idx_q;
    logic [3:0]  wr_be_q;
    logic        rd_vld_q, fwd_q;
    logic [3:0]  fwd_be_q;
    logic [31:0] fwd_data_q;
    logic        accept, invalid, valid_acc, rd_acc, commit, fwd;
    logic [3:0]  be;
    idx_t        idx;
    logic [4:0]  penalty, wait_d;
    logic [31:0] ram_rd, fwd_bits;
    logic        unused_ok;

    assign accept    = bus.HSEL & bus.HTRANS[1] & hready_q;
    assign idx       = bus.HADDR[ADDR_WIDTH+1:2];
    assign invalid   = bus.HSIZE > 3'd2 || (bus.HSIZE == HS_HALF && bus.HADDR[0])
                       || (bus.HSIZE == HS_WORD && bus.HADDR[1:0] != 2'b00);
    assign valid_acc = accept & ~invalid;
    assign rd_acc    = valid_acc & ~bus.HWRITE;
    assign be        = lane_mask(bus.HSIZE, bus.HADDR[1:0]);
    // The data phase ends on the first HREADY-high cycle after acceptance; reset drops it.
    assign commit    = wr_pend_q & hready_q & ~HRESET;
    assign fwd       = rd_acc & commit & wr_idx_q == idx;
    assign wait_d    = 5'(WAIT_STATES) + penalty;
    assign unused_ok = ^{bus.HBURST, bus.HTRANS[0], bus.HADDR[31:ADDR_WIDTH+2]};

`ifdef AHB_MEM_REFRESH_EN
    localparam int RW = $clog2(REFRESH_PERIOD);
    logic [RW-1:0] ref_cnt_q;
    logic          ref_pend_q, ref_tick;

    assign ref_tick = ref_cnt_q == RW'(REFRESH_PERIOD - 1);
    assign penalty  = ref_pend_q ? 5'(REFRESH_CYCLES) : 5'd0;

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            ref_cnt_q  <= '0;
            ref_pend_q <= 1'b0;
        end else begin
            ref_cnt_q  <= ref_tick ? '0 : ref_cnt_q + 1'b1;
            ref_pend_q <= ref_tick | (ref_pend_q & ~valid_acc);
        end
    end
`else
    logic unused_cfg_ok;
    assign penalty       = 5'd0;
    assign unused_cfg_ok = ^{32'(REFRESH_PERIOD), 32'(REFRESH_CYCLES)};
`endif

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            hready_q  <= 1'b1;
            hresp_q   <= 1'b0;
            wr_pend_q <= 1'b0;
            rd_vld_q  <= 1'b0;
            fwd_q     <= 1'b0;
        end else begin
            if (commit) wr_pend_q <= 1'b0;
            if (rd_acc) begin
                rd_vld_q   <= 1'b1;
                fwd_q      <= fwd;
                fwd_be_q   <= wr_be_q;
                fwd_data_q <= bus.HWDATA;
            end
            if (accept && invalid) begin
                state_q  <= S_ERR1;
                hready_q <= 1'b0;
                hresp_q  <= 1'b1;
            end else if (accept) begin
                wr_pend_q <= bus.HWRITE;
                wr_idx_q  <= idx;
                wr_be_q   <= be;
                state_q   <= wait_d == 5'd0 ? S_IDLE : S_WAIT;
                cnt_q     <= wait_d - 5'd1;
                hready_q  <= wait_d == 5'd0;
                hresp_q   <= 1'b0;
            end else begin
                case (state_q)
                    S_WAIT: begin
                        cnt_q    <= cnt_q - 5'd1;
                        state_q  <= cnt_q == 5'd0 ? S_IDLE : S_WAIT;
                        hready_q <= cnt_q == 5'd0;
                    end
                    S_ERR1: begin
                        state_q  <= S_ERR2;
                        hready_q <= 1'b1;
                    end
                    S_ERR2: begin
                        state_q <= S_IDLE;
                        hresp_q <= 1'b0;
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    ahb_lite_mem_ram #(.ADDR_WIDTH(ADDR_WIDTH)) u_ram (
        .clk     (HCLK),
        .be_i    (commit ? wr_be_q : 4'b0000),
        .waddr_i (wr_idx_q),
        .wdata_i (bus.HWDATA),
        .re_i    (rd_acc),
        .raddr_i (idx),
        .rdata_o (ram_rd)
    );

    // A read that overlapped a same-word write commit sees that write's lanes.
    assign fwd_bits   = be_bits(fwd_be_q);
    assign bus.HRDATA = !rd_vld_q ? 32'd0 : fwd_q ? (ram_rd & ~fwd_bits) | (fwd_data_q & fwd_bits) : ram_rd;
    assign bus.HREADY = hready_q;
    assign bus.HRESP  = hresp_q;
endmodule

// File: tb/tb_ahb_lite_wait_mem.sv
// tb_ahb_lite_wait_mem: randomized pipelined AHB-Lite master against three memories (0, 2 and 1 wait states)
// checked by a word-array reference model.
module tb_ahb_lite_wait_mem;
    logic clk = 1'b0, rst = 1'b1;
    always #5 clk = ~clk;

    logic [31:0] haddr, hwdata;
    logic [2:0]  hsize;
    logic [1:0]  htrans;
    logic        hwrite, hsel;
    int          sel;
    logic [2:0]  rdy_v, rsp_v;
    logic [31:0] rd_v [3];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        ahb_lite_wait_mem_if bus ();
        assign bus.HADDR  = haddr;
        assign bus.HBURST = 3'd0;
        assign bus.HSEL   = hsel && sel == g;
        assign bus.HSIZE  = hsize;
        assign bus.HTRANS = htrans;
        assign bus.HWDATA = hwdata;
        assign bus.HWRITE = hwrite;
        assign rdy_v[g]   = bus.HREADY;
        assign rsp_v[g]   = bus.HRESP;
        assign rd_v[g]    = bus.HRDATA;
        ahb_lite_wait_mem #(
            .ADDR_WIDTH(10), .WAIT_STATES(g == 0 ? 0 : g == 1 ? 2 : 1),
            .REFRESH_PERIOD(8), .REFRESH_CYCLES(3)
        ) dut (.HCLK(clk), .HRESET(rst), .bus(bus));
    end

    typedef struct {bit wr; logic [31:0] addr; logic [2:0] size; logic [31:0] wdata;} xfer_t;
    xfer_t       dq [$];
    logic [31:0] mdl [3][32];
    logic [31:0] last_rd;
    int          edges = 0;
    int          last_cons [3];
    int          checks = 0, errors = 0;

    always @(posedge clk) edges <= rst ? 0 : edges + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic int ws_of(input int k);
        return k == 0 ? 0 : k == 1 ? 2 : 1;
    endfunction

    // Refresh requests land on every 8th edge after reset; one pending request is charged to the next valid transfer.
    function automatic int penalty(input int k, input int e);
`ifdef AHB_MEM_REFRESH_EN
        int req;
        req = ((e - 1) / 8) * 8;
        if (req > last_cons[k]) begin
            last_cons[k] = req;
            return 3;
        end
`endif
        return 0;
    endfunction

    task automatic push(input bit wr, input logic [31:0] a, input logic [2:0] s, input logic [31:0] d);
        xfer_t x;
        x.wr = wr; x.addr = a; x.size = s; x.wdata = d;
        dq.push_back(x);
    endtask

    task automatic run(input int k, input int nrand);
        bit          dv = 0, dw = 0, derr = 0;
        int          dwait = 0, low = 0, budget = 0, r;
        logic [4:0]  didx = 0;
        logic [3:0]  dbe = 0;
        logic [31:0] drexp = 0, dwdata = 0;
        xfer_t       x;
        sel = k;
        while ((dq.size() > 0 || nrand > 0 || dv) && budget < 4000) begin
            hwdata = dv && dw ? dwdata : $urandom;
            if (dv && !rdy_v[k]) begin
                low++;
                chk("resp_low", 32'(rsp_v[k]), 32'(derr));
            end else if (dv) begin
                chk("low_cycles", low, derr ? 1 : dwait);
                chk("resp_end", 32'(rsp_v[k]), 32'(derr));
                if (!dw && !derr) begin
                    chk("rdata", rd_v[k], drexp);
                    last_rd = rd_v[k];
                end
                if (dw && !derr)
                    for (int b = 0; b < 4; b++) if (dbe[b]) mdl[k][didx][8*b +: 8] = dwdata[8*b +: 8];
                dv = 0;
            end else chk("idle_rdy", 32'(rdy_v[k]), 32'd1);
            if (rdy_v[k] && (dq.size() > 0 || (nrand > 0 && $urandom_range(0, 3) != 0))) begin
                if (dq.size() > 0) x = dq.pop_front();
                else begin
                    nrand--;
                    r = $urandom_range(0, 9);
                    x.wr = 1'($urandom_range(0, 1));
                    x.size = r < 3 ? 3'd0 : r < 6 ? 3'd1 : r < 9 ? 3'd2 : 3'($urandom_range(3, 7));
                    x.addr = ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 127));
                    if ($urandom_range(0, 3) != 0)
                        x.addr = x.size == 3'd1 ? x.addr & ~32'h1 : x.size == 3'd2 ? x.addr & ~32'h3 : x.addr;
                    x.wdata = $urandom;
                end
                haddr = x.addr; hsize = x.size; hwrite = x.wr; hsel = 1'b1;
                htrans = $urandom_range(0, 1) ? 2'b10 : 2'b11;
                dv = 1; low = 0; dw = x.wr; dwdata = x.wdata; didx = x.addr[6:2];
                derr = x.size > 3'd2 || (x.size == 3'd1 && x.addr[0]) || (x.size == 3'd2 && x.addr[1:0] != 2'b00);
                dbe = x.size == 3'd0 ? 4'b0001 << x.addr[1:0] : x.size == 3'd1 ? 4'b0011 << x.addr[1:0] : 4'b1111;
                if (!derr) begin
                    dwait = ws_of(k) + penalty(k, edges + 1);
                    drexp = mdl[k][didx];
                end
            end else begin
                haddr = ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 127));
                hsize = 3'($urandom_range(0, 2));
                hwrite = 1'($urandom_range(0, 1));
                if ($urandom_range(0, 1) != 0) begin
                    hsel = 1'b1; htrans = 2'($urandom_range(0, 1));
                end else begin
                    hsel = 1'b0; htrans = 2'b10;
                end
            end
            @(posedge clk); #1;
            budget++;
        end
        chk("drained", 32'(dv), 32'd0);
        hsel = 1'b0; htrans = 2'b00;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout");
        $fatal(1);
    end

    initial begin
        haddr = 0; hwdata = 0; hsize = 0; htrans = 0; hwrite = 0; hsel = 0; sel = 0; last_rd = 0;
        for (int k = 0; k < 3; k++) last_cons[k] = 0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("rst_hready", 32'(rdy_v[k]), 32'd1);
            chk("rst_hresp", 32'(rsp_v[k]), 32'd0);
            chk("rst_hrdata", rd_v[k], 32'd0);
        end
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 32; i++) push(1, 32'(i * 4), 3'd2, $urandom);
            run(k, 0);
        end
        push(1, 32'h10, 3'd2, 32'hDEADBEEF);
        push(0, 32'h10, 3'd2, 32'h0);
        run(0, 0);
        chk("fwd_deadbeef", last_rd, 32'hDEADBEEF);
        run(0, 300);
        push(1, 32'h20, 3'd2, 32'h11223344);
        push(1, 32'h21, 3'd0, 32'h0000AA00);
        push(0, 32'h20, 3'd2, 32'h0);
        run(1, 0);
        chk("byte_merge", last_rd, 32'h1122AA44);
        push(1, 32'h03, 3'd1, 32'hFFFFFFFF);
        push(0, 32'h00, 3'd2, 32'h0);
        run(1, 0);
        run(1, 300);
        for (int i = 0; i < 24; i++) push(0, 32'($urandom_range(0, 31) * 4), 3'd2, 32'h0);
        run(2, 300);
        push(1, 32'h40, 3'd2, 32'h5555AAAA);
        run(1, 0);
        sel = 1; haddr = 32'h40; hsize = 3'd2; hwrite = 1'b1; htrans = 2'b10; hsel = 1'b1;
        @(posedge clk); #1;
        htrans = 2'b00; hsel = 1'b0; hwdata = 32'h12345678;
        chk("rst_wait_low", 32'(rdy_v[1]), 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int k = 0; k < 3; k++) last_cons[k] = 0;
        chk("rst_mid_hready", 32'(rdy_v[1]), 32'd1);
        chk("rst_mid_hresp", 32'(rsp_v[1]), 32'd0);
        chk("rst_mid_hrdata", rd_v[1], 32'd0);
        push(0, 32'h40, 3'd2, 32'h0);
        run(1, 0);
        chk("rst_drop_write", last_rd, 32'h5555AAAA);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
